// File: rtl/decim_chain_seq_if.sv
// Output sample stream of the decimation-chain sequencer: valid/ready handshake
// carrying one chain output sample per transfer.
interface decim_chain_seq_if #(
  parameter int unsigned DATA_WIDTH = 50
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  // Producer side (the sequencer FIFO head)
  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  // Consumer side
  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/decim_chain_seq.sv
// Run-control sequencer for the CIC/FIR/halfband decimation chain.
// Holds the chain in reset while idle, flushes it on start, gates the modulator
// strobe into the chain, discards start-up transient samples and buffers
// settled samples in a small FIFO behind a registered valid/ready output.
// Optional inactivity watchdog: define DECIM_SEQ_TIMEOUT_EN to enable it.
module decim_chain_seq #(
  parameter int unsigned DATA_WIDTH     = 50,
  parameter int unsigned FLUSH_CYCLES   = 8,
  parameter int unsigned SETTLE_SAMPLES = 16,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mod_valid,
  output logic                  chain_in_valid,
  output logic                  chain_rst_n,
  input  logic                  chain_out_valid,
  input  logic [DATA_WIDTH-1:0] chain_out_data,
  decim_chain_seq_if.master     m_if,
  output logic                  busy,
  output logic                  settled,
  output logic                  overflow,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  sample_count
);

  localparam int unsigned FlushW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned SettleW = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES + 1) : 1;
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW  = $clog2(FIFO_DEPTH + 1);

  // Flush counter counts down to zero, so FLUSH lasts exactly FLUSH_CYCLES cycles.
  localparam logic [FlushW-1:0]  FlushLoad  = FlushW'(FLUSH_CYCLES - 1);
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE_SAMPLES);
  localparam logic [CountW-1:0]  CountFull  = CountW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StSettle,
    StRun,
    StDrain
  } state_e;

  state_e                state_q, state_d;
  logic [FlushW-1:0]     flush_cnt_q, flush_cnt_d;
  logic [SettleW-1:0]    settle_cnt_q, settle_cnt_d;

  logic                  chain_rst_n_q, chain_rst_n_d;
  logic                  busy_q, busy_d;
  logic                  settled_q, settled_d;
  logic                  overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]  sample_count_q, sample_count_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]     count_q, count_d;
  logic [CountW-1:0]     remaining;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

  logic                  clr_stats;
  logic                  full;
  logic                  pop;
  logic                  push_req;
  logic                  push;
  logic                  drop;
  logic                  wd_expire;

  // ---------------------------------------------------------------------------
  // Handshake / FIFO control terms
  // ---------------------------------------------------------------------------
  assign full     = (count_q == CountFull);
  assign pop      = m_valid_q & m_if.m_ready;
  assign push_req = (state_q == StRun) & chain_out_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // ---------------------------------------------------------------------------
  // Optional inactivity watchdog
  // ---------------------------------------------------------------------------
`ifdef DECIM_SEQ_TIMEOUT_EN
  localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic           wd_active;
  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic           timeout_q, timeout_d;

  assign wd_active = (state_q == StSettle) | (state_q == StRun);
  // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a chain output.
  assign wd_expire = wd_active & ~chain_out_valid & (wd_cnt_q == WdLast);

  // Watchdog next state: restart on every chain output and outside SETTLE/RUN
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (!wd_active || chain_out_valid) begin
      wd_cnt_d = '0;
    end else if (!wd_expire) begin
      wd_cnt_d = wd_cnt_q + WdW'(1);
    end
    if (clr_stats) begin
      timeout_d = 1'b0;
    end else if (wd_expire) begin
      timeout_d = 1'b1;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign wd_expire          = 1'b0;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer next state
  // ---------------------------------------------------------------------------
  // Run-control FSM transitions and phase counters
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    settle_cnt_d = settle_cnt_q;
    clr_stats    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StFlush;
          flush_cnt_d = FlushLoad;
          clr_stats   = 1'b1;
        end
      end

      StFlush: begin
        if (stop) begin
          state_d = StIdle;
        end else if (flush_cnt_q == '0) begin
          state_d      = (SETTLE_SAMPLES == 0) ? StRun : StSettle;
          settle_cnt_d = SettleLoad;
        end else begin
          flush_cnt_d = flush_cnt_q - FlushW'(1);
        end
      end

      StSettle: begin
        if (stop) begin
          state_d = StDrain;
        end else if (chain_out_valid) begin
          if (settle_cnt_q == SettleW'(1)) begin
            state_d = StRun;
          end
          settle_cnt_d = settle_cnt_q - SettleW'(1);
        end else if (wd_expire) begin
          state_d = StDrain;
        end
      end

      StRun: begin
        if (stop || wd_expire) begin
          state_d = StDrain;
        end
      end

      StDrain: begin
        if (count_q == '0) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered status outputs follow the next state so they align with it
  always_comb begin
    chain_rst_n_d  = (state_d == StSettle) | (state_d == StRun);
    busy_d         = (state_d != StIdle);
    settled_d      = (state_d == StRun);
    overflow_d     = overflow_q;
    sample_count_d = sample_count_q;

    if (clr_stats) begin
      overflow_d     = 1'b0;
      sample_count_d = '0;
    end else begin
      if (drop) begin
        overflow_d = 1'b1;
      end
      if (push && (sample_count_q != {CNT_WIDTH{1'b1}})) begin
        sample_count_d = sample_count_q + CNT_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO next state
  // ---------------------------------------------------------------------------
  // Storage, pointers, occupancy and the registered head (m_valid/m_data)
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = chain_out_data;
    end

    wr_ptr_d  = push ? (wr_ptr_q + PtrW'(1)) : wr_ptr_q;
    rd_ptr_d  = pop ? (rd_ptr_q + PtrW'(1)) : rd_ptr_q;
    count_d   = count_q + CountW'(push) - CountW'(pop);
    remaining = count_q - CountW'(pop);

    m_valid_d = (count_d != '0);
    m_data_d  = m_data_q;
    if (count_d != '0) begin
      // Nothing left after the pop: the head is the sample being pushed now.
      if (remaining == '0) begin
        m_data_d = chain_out_data;
      end else begin
        m_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Control and status state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      flush_cnt_q    <= '0;
      settle_cnt_q   <= '0;
      chain_rst_n_q  <= 1'b0;
      busy_q         <= 1'b0;
      settled_q      <= 1'b0;
      overflow_q     <= 1'b0;
      sample_count_q <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      m_valid_q      <= 1'b0;
      m_data_q       <= '0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      settle_cnt_q   <= settle_cnt_d;
      chain_rst_n_q  <= chain_rst_n_d;
      busy_q         <= busy_d;
      settled_q      <= settled_d;
      overflow_q     <= overflow_d;
      sample_count_q <= sample_count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
    end
  end

  // FIFO storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign chain_in_valid = mod_valid & ((state_q == StSettle) | (state_q == StRun));
  assign chain_rst_n    = chain_rst_n_q;
  assign busy           = busy_q;
  assign settled        = settled_q;
  assign overflow       = overflow_q;
  assign sample_count   = sample_count_q;
  assign m_if.m_valid   = m_valid_q;
  assign m_if.m_data    = m_data_q;

endmodule

// File: tb/tb_decim_chain_seq.sv
// Scoreboard bench for decim_chain_seq (default parameters, watchdog disabled).
module tb_decim_chain_seq;

  localparam int unsigned DW = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mod_valid = 1'b0;
  logic          chain_out_valid = 1'b0;
  logic [DW-1:0] chain_out_data = '0;
  logic          chain_in_valid;
  logic          chain_rst_n;
  logic          busy;
  logic          settled;
  logic          overflow;
  logic          timeout;
  logic [15:0]   sample_count;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  decim_chain_seq_if #(.DATA_WIDTH(DW)) m_if ();

  decim_chain_seq dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .stop            (stop),
    .mod_valid       (mod_valid),
    .chain_in_valid  (chain_in_valid),
    .chain_rst_n     (chain_rst_n),
    .chain_out_valid (chain_out_valid),
    .chain_out_data  (chain_out_data),
    .m_if            (m_if),
    .busy            (busy),
    .settled         (settled),
    .overflow        (overflow),
    .timeout         (timeout),
    .sample_count    (sample_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_out(input logic [DW-1:0] d);
    chain_out_valid = 1'b1;
    chain_out_data  = d;
    tick();
    chain_out_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(busy), 64'(0));
  endtask

  // Monitor: every accepted output beat is checked against the scoreboard head
  always @(negedge clk) begin
    if (!rst && m_if.m_valid && m_if.m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0d expected no sample", m_if.m_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (m_if.m_data !== mon_exp) begin
          errors++;
          $display("FAIL pop_data: got %0d expected %0d", m_if.m_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    m_if.m_ready = 1'b0;
    mod_valid    = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_chain_rst_n", 64'(chain_rst_n), 64'(0));
    chk("rst_chain_in_valid", 64'(chain_in_valid), 64'(0));
    chk("rst_m_valid", 64'(m_if.m_valid), 64'(0));
    chk("rst_m_data", 64'(m_if.m_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_settled", 64'(settled), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    chk("rst_sample_count", 64'(sample_count), 64'(0));
    rst = 1'b0;
    tick();

    // Start and flush: chain held in reset for 8 cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("flush_busy", 64'(busy), 64'(1));
    chk("flush_in_valid_gated", 64'(chain_in_valid), 64'(0));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("flush_rst_n_%0d", i), 64'(chain_rst_n), 64'(0));
      tick();
    end
    chk("settle_rst_n", 64'(chain_rst_n), 64'(1));
    chk("settle_in_valid_hi", 64'(chain_in_valid), 64'(1));
    mod_valid = 1'b0;
    #1;
    chk("settle_in_valid_lo", 64'(chain_in_valid), 64'(0));

    // Settle discard: 1..16 dropped, 17..20 delivered at full rate
    m_if.m_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 16) chk("settled_before_16", 64'(settled), 64'(0));
      if (i >= 17) exp_q.push_back(DW'(i));
      pulse_out(DW'(i));
      if (i == 16) chk("settled_after_16", 64'(settled), 64'(1));
    end
    repeat (2) tick();
    chk("settle_m_valid_empty", 64'(m_if.m_valid), 64'(0));
    chk("settle_sample_count", 64'(sample_count), 64'(4));

    // Backpressure overflow: 100..103 kept, 104/105 dropped
    m_if.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_q.push_back(DW'(100 + i));
      pulse_out(DW'(100 + i));
    end
    chk("ovf_flag", 64'(overflow), 64'(1));
    chk("ovf_sample_count", 64'(sample_count), 64'(8));
    chk("ovf_m_valid", 64'(m_if.m_valid), 64'(1));
    chk("ovf_head", 64'(m_if.m_data), 64'(100));
    tick();
    chk("ovf_head_stable", 64'(m_if.m_data), 64'(100));
    m_if.m_ready = 1'b1;
    repeat (4) tick();
    chk("ovf_drained", 64'(m_if.m_valid), 64'(0));

    // Stop with buffered samples: drain under backpressure then release
    m_if.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(DW'(110 + i));
      pulse_out(DW'(110 + i));
    end
    mod_valid = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("drain_rst_n", 64'(chain_rst_n), 64'(0));
    chk("drain_in_valid", 64'(chain_in_valid), 64'(0));
    chk("drain_busy", 64'(busy), 64'(1));
    chk("drain_settled", 64'(settled), 64'(0));
    chk("drain_head", 64'(m_if.m_data), 64'(110));
    chk("drain_sample_count", 64'(sample_count), 64'(11));
    pulse_out(DW'(999));  // ignored while draining
    tick();
    chk("drain_busy_held", 64'(busy), 64'(1));
    m_if.m_ready = 1'b1;
    wait_idle("drain_to_idle", 20);

    // Restart clears status; full FIFO with simultaneous push/pop
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_overflow_clr", 64'(overflow), 64'(0));
    chk("restart_count_clr", 64'(sample_count), 64'(0));
    repeat (8) tick();
    for (int i = 0; i < 16; i++) pulse_out(DW'(0));
    chk("restart_settled", 64'(settled), 64'(1));
    m_if.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(DW'(200 + i));
      pulse_out(DW'(200 + i));
    end
    m_if.m_ready = 1'b1;
    exp_q.push_back(DW'(204));
    pulse_out(DW'(204));
    chk("full_pushpop_no_ovf", 64'(overflow), 64'(0));
    exp_q.push_back(DW'(205));
    pulse_out(DW'(205));
    repeat (6) tick();
    chk("full_pushpop_empty", 64'(m_if.m_valid), 64'(0));
    chk("full_pushpop_count", 64'(sample_count), 64'(6));
    chk("full_pushpop_ovf_end", 64'(overflow), 64'(0));

    // Stop from RUN with empty FIFO, then stop during FLUSH
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_run_busy", 64'(busy), 64'(1));
    tick();
    chk("stop_run_idle", 64'(busy), 64'(0));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_flush_idle", 64'(busy), 64'(0));
    chk("stop_flush_rst_n", 64'(chain_rst_n), 64'(0));

    // Reset mid-flush aborts
    start = 1'b1;
    tick();
    start = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    tick();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    chk("timeout_off", 64'(timeout), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
